// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU stage/instruction encodings and writeback entry type.
// Used by regfile_wb_ctrl (optional feature macro: REGFILE_ZERO_REG_EN).
package tinycpu_pkg;

  localparam logic [2:0] STAGE_FETCH           = 3'd0;
  localparam logic [2:0] STAGE_DECODE          = 3'd1;
  localparam logic [2:0] STAGE_MEMORY_READ     = 3'd2;
  localparam logic [2:0] STAGE_EXECUTE         = 3'd3;
  localparam logic [2:0] STAGE_REGISTER_UPDATE = 3'd4;

  localparam logic [4:0] INSTR_NO_OP          = 5'd0;
  localparam logic [4:0] INSTR_LOAD_IMMEDIATE = 5'd1;
  localparam logic [4:0] INSTR_LOAD           = 5'd2;
  localparam logic [4:0] INSTR_ALU_OP         = 5'd5;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic instr_writes_rf(input logic [4:0] t);
    return (t == INSTR_LOAD_IMMEDIATE) || (t == INSTR_LOAD) || (t == INSTR_ALU_OP);
  endfunction

  function automatic logic instr_is_legal(input logic [4:0] t);
    return (t == INSTR_NO_OP) || instr_writes_rf(t);
  endfunction

endpackage

// File: rtl/regfile_wb_queue.sv
// Circular writeback FIFO with two youngest-match forwarding lookups.
// A lookup also sees the entry being pushed in the same cycle.
module regfile_wb_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [ADDR_WIDTH-1:0]     push_addr,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [ADDR_WIDTH-1:0]     head_addr,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  input  logic [ADDR_WIDTH-1:0]     lookup_addr_0,
  input  logic [ADDR_WIDTH-1:0]     lookup_addr_1,
  output logic                      hit_0,
  output logic                      hit_1,
  output logic [DATA_WIDTH-1:0]     data_0,
  output logic [DATA_WIDTH-1:0]     data_1
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  do_push, do_pop;

  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end
    count_d = count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
  end

  // Scan oldest to youngest so later matches win; the incoming push is youngest of all.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx;
    hit_0  = 1'b0;
    hit_1  = 1'b0;
    data_0 = '0;
    data_1 = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_WIDTH'(i);
      if (CNT_WIDTH'(i) < count_q) begin
        if (addr_q[idx] == lookup_addr_0) begin
          hit_0  = 1'b1;
          data_0 = data_q[idx];
        end
        if (addr_q[idx] == lookup_addr_1) begin
          hit_1  = 1'b1;
          data_1 = data_q[idx];
        end
      end
    end
    if (do_push && (push_addr == lookup_addr_0)) begin
      hit_0  = 1'b1;
      data_0 = push_data;
    end
    if (do_push && (push_addr == lookup_addr_1)) begin
      hit_1  = 1'b1;
      data_1 = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// TinyCPU register file with a buffered writeback queue and operand forwarding.
// Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.
module regfile_wb_ctrl
  import tinycpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    stage,
  input  logic [4:0]                    instr_type,
  input  logic [ADDR_WIDTH-1:0]         load_imm_reg,
  input  logic [DATA_WIDTH-1:0]         load_imm_data,
  input  logic [ADDR_WIDTH-1:0]         load_mem_reg,
  input  logic [DATA_WIDTH-1:0]         load_mem_data,
  input  logic [ADDR_WIDTH-1:0]         alu_reg_0,
  input  logic [ADDR_WIDTH-1:0]         alu_reg_1,
  input  logic [ADDR_WIDTH-1:0]         alu_reg_res,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          ext_we,
  input  logic [ADDR_WIDTH-1:0]         ext_addr,
  input  logic [DATA_WIDTH-1:0]         ext_data,
  output logic [DATA_WIDTH-1:0]         read_data_0,
  output logic [DATA_WIDTH-1:0]         read_data_1,
  output logic                          read_valid,
  output logic                          stall,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic                          illegal_instr
);

  localparam int ENTRIES = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [DATA_WIDTH-1:0] mem_d [ENTRIES];
  logic [DATA_WIDTH-1:0] read_data_0_q, read_data_0_d;
  logic [DATA_WIDTH-1:0] read_data_1_q, read_data_1_d;
  logic                  read_valid_q, read_valid_d;
  logic                  illegal_instr_q, illegal_instr_d;

  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_req, push, pop, ext_wr;
  logic [ADDR_WIDTH-1:0] rd_addr_0, rd_addr_1;
  logic [ADDR_WIDTH-1:0] q_head_addr;
  logic [DATA_WIDTH-1:0] q_head_data, fwd_data_0, fwd_data_1;
  logic                  q_full, q_empty, fwd_hit_0, fwd_hit_1;

  always_comb begin
    wb_addr = '0;
    wb_data = '0;
    case (instr_type)
      INSTR_LOAD_IMMEDIATE: begin
        wb_addr = load_imm_reg;
        wb_data = load_imm_data;
      end
      INSTR_LOAD: begin
        wb_addr = load_mem_reg;
        wb_data = load_mem_data;
      end
      INSTR_ALU_OP: begin
        wb_addr = alu_reg_res;
        wb_data = alu_result;
      end
      default: ;
    endcase
  end

`ifdef REGFILE_ZERO_REG_EN
  assign wb_req = (stage == STAGE_REGISTER_UPDATE) && instr_writes_rf(instr_type) && (wb_addr != '0);
  assign ext_wr = ext_we && (ext_addr != '0);
`else
  assign wb_req = (stage == STAGE_REGISTER_UPDATE) && instr_writes_rf(instr_type);
  assign ext_wr = ext_we;
`endif

  // Full is judged before this cycle's drain, so a stalled write waits one more cycle.
  assign push  = wb_req && !q_full;
  assign stall = wb_req && q_full;
  assign pop   = !q_empty && !ext_wr;

  assign rd_addr_0 = (instr_type == INSTR_ALU_OP) ? alu_reg_0 : '0;
  assign rd_addr_1 = (instr_type == INSTR_ALU_OP) ? alu_reg_1 : '0;

  regfile_wb_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_addr     (wb_addr),
    .push_data     (wb_data),
    .pop           (pop),
    .head_addr     (q_head_addr),
    .head_data     (q_head_data),
    .count         (queue_count),
    .full          (q_full),
    .empty         (q_empty),
    .lookup_addr_0 (rd_addr_0),
    .lookup_addr_1 (rd_addr_1),
    .hit_0         (fwd_hit_0),
    .hit_1         (fwd_hit_1),
    .data_0        (fwd_data_0),
    .data_1        (fwd_data_1)
  );

  always_comb begin
    mem_d = mem_q;
    if (ext_wr) begin
      mem_d[ext_addr] = ext_data;
    end else if (pop) begin
      mem_d[q_head_addr] = q_head_data;
    end
  end

  // Operands come from the youngest queued write when present, else the pre-write array.
  always_comb begin
    read_data_0_d = fwd_hit_0 ? fwd_data_0 : mem_q[rd_addr_0];
    read_data_1_d = fwd_hit_1 ? fwd_data_1 : mem_q[rd_addr_1];
`ifdef REGFILE_ZERO_REG_EN
    if (rd_addr_0 == '0) read_data_0_d = '0;
    if (rd_addr_1 == '0) read_data_1_d = '0;
`endif
    read_valid_d    = (stage == STAGE_MEMORY_READ) && (instr_type == INSTR_ALU_OP);
    illegal_instr_d = illegal_instr_q ||
                      ((stage == STAGE_REGISTER_UPDATE) && !instr_is_legal(instr_type));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q           <= '{default: '0};
      read_data_0_q   <= '0;
      read_data_1_q   <= '0;
      read_valid_q    <= 1'b0;
      illegal_instr_q <= 1'b0;
    end else begin
      mem_q           <= mem_d;
      read_data_0_q   <= read_data_0_d;
      read_data_1_q   <= read_data_1_d;
      read_valid_q    <= read_valid_d;
      illegal_instr_q <= illegal_instr_d;
    end
  end

  assign read_data_0   = read_data_0_q;
  assign read_data_1   = read_data_1_q;
  assign read_valid    = read_valid_q;
  assign illegal_instr = illegal_instr_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl against a queue/array reference model.
// Honours REGFILE_ZERO_REG_EN in the model when the macro is defined.
module tb_regfile_wb_ctrl;
  import tinycpu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        rst;
    logic [2:0]  stage;
    logic [4:0]  instr;
    logic [4:0]  li_reg;
    logic [31:0] li_data;
    logic [4:0]  lm_reg;
    logic [31:0] lm_data;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  ar;
    logic [31:0] ares;
    logic        ext_we;
    logic [4:0]  ext_addr;
    logic [31:0] ext_data;
  } stim_t;

  typedef struct packed {
    logic [2:0]  count;
    logic        stall;
    logic        illegal;
    logic        rv;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } status_t;

  typedef struct packed {
    logic [31:0] rd0;
    logic [31:0] rd1;
  } operands_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  stage;
  logic [4:0]  instr_type;
  logic [4:0]  load_imm_reg, load_mem_reg, alu_reg_0, alu_reg_1, alu_reg_res, ext_addr;
  logic [31:0] load_imm_data, load_mem_data, alu_result, ext_data;
  logic        ext_we;
  logic [31:0] read_data_0, read_data_1;
  logic        read_valid, stall, illegal_instr;
  logic [2:0]  queue_count;

  int passCount  = 0;
  int totalCount = 0;

  logic [31:0] refRegs [32];
  wb_entry_t   refQ [$];
  logic        refIllegal;
  logic        refRv;
  logic [31:0] refRd0, refRd1;
  status_t     statusQ [$];
  operands_t   operandQ [$];

  regfile_wb_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .QUEUE_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stage         (stage),
    .instr_type    (instr_type),
    .load_imm_reg  (load_imm_reg),
    .load_imm_data (load_imm_data),
    .load_mem_reg  (load_mem_reg),
    .load_mem_data (load_mem_data),
    .alu_reg_0     (alu_reg_0),
    .alu_reg_1     (alu_reg_1),
    .alu_reg_res   (alu_reg_res),
    .alu_result    (alu_result),
    .ext_we        (ext_we),
    .ext_addr      (ext_addr),
    .ext_data      (ext_data),
    .read_data_0   (read_data_0),
    .read_data_1   (read_data_1),
    .read_valid    (read_valid),
    .stall         (stall),
    .queue_count   (queue_count),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.stage = STAGE_FETCH;
    s.instr = INSTR_NO_OP;
    return s;
  endfunction

  function automatic stim_t loadImm(input logic [4:0] r, input logic [31:0] d, input logic we);
    stim_t s;
    s = idle();
    s.stage = STAGE_REGISTER_UPDATE;
    s.instr = INSTR_LOAD_IMMEDIATE;
    s.li_reg = r;
    s.li_data = d;
    s.ext_we = we;
    s.ext_addr = 5'd20;
    s.ext_data = 32'hAAAA_0000 | {27'd0, r};
    return s;
  endfunction

  function automatic stim_t aluRead(input logic [4:0] r0, input logic [4:0] r1);
    stim_t s;
    s = idle();
    s.stage = STAGE_MEMORY_READ;
    s.instr = INSTR_ALU_OP;
    s.a0 = r0;
    s.a1 = r1;
    return s;
  endfunction

  function automatic logic [31:0] refLookup(input logic [4:0] a, input logic pushing, input wb_entry_t pe);
`ifdef REGFILE_ZERO_REG_EN
    if (a == 5'd0) return 32'd0;
`endif
    if (pushing && pe.addr == a) return pe.data;
    for (int i = refQ.size() - 1; i >= 0; i--)
      if (refQ[i].addr == a) return refQ[i].data;
    return refRegs[a];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    refQ.delete();
    refIllegal = 1'b0;
    refRv = 1'b0;
    refRd0 = 32'd0;
    refRd1 = 32'd0;
  endtask

  // Drive one cycle, record what the DUT must show during it, then advance the model.
  task automatic applyStimulus(input stim_t s);
    wb_entry_t pe;
    logic      writes, wbReq, pushOk, extEff, newRv;
    logic [4:0] r0, r1;
    logic [31:0] n0, n1;
    status_t   st;

    rst = s.rst; stage = s.stage; instr_type = s.instr;
    load_imm_reg = s.li_reg; load_imm_data = s.li_data;
    load_mem_reg = s.lm_reg; load_mem_data = s.lm_data;
    alu_reg_0 = s.a0; alu_reg_1 = s.a1; alu_reg_res = s.ar; alu_result = s.ares;
    ext_we = s.ext_we; ext_addr = s.ext_addr; ext_data = s.ext_data;

    writes = 1'b1;
    pe = '0;
    if (s.instr == INSTR_LOAD_IMMEDIATE) begin pe.addr = s.li_reg; pe.data = s.li_data; end
    else if (s.instr == INSTR_LOAD) begin pe.addr = s.lm_reg; pe.data = s.lm_data; end
    else if (s.instr == INSTR_ALU_OP) begin pe.addr = s.ar; pe.data = s.ares; end
    else writes = 1'b0;
    wbReq = (s.stage == STAGE_REGISTER_UPDATE) && writes;
    extEff = s.ext_we;
`ifdef REGFILE_ZERO_REG_EN
    if (pe.addr == 5'd0) wbReq = 1'b0;
    if (s.ext_addr == 5'd0) extEff = 1'b0;
`endif

    st.count = 3'(refQ.size());
    st.stall = wbReq && (refQ.size() == DEPTH);
    st.illegal = refIllegal;
    st.rv = refRv;
    st.rd0 = refRd0;
    st.rd1 = refRd1;
    statusQ.push_back(st);

    if (s.rst) begin
      modelReset();
    end else begin
      pushOk = wbReq && (refQ.size() < DEPTH);
      r0 = (s.instr == INSTR_ALU_OP) ? s.a0 : 5'd0;
      r1 = (s.instr == INSTR_ALU_OP) ? s.a1 : 5'd0;
      n0 = refLookup(r0, pushOk, pe);
      n1 = refLookup(r1, pushOk, pe);
      newRv = (s.stage == STAGE_MEMORY_READ) && (s.instr == INSTR_ALU_OP);
      if (newRv) operandQ.push_back('{rd0: n0, rd1: n1});
      if (extEff) refRegs[s.ext_addr] = s.ext_data;
      else if (refQ.size() > 0) begin
        wb_entry_t e;
        e = refQ.pop_front();
        refRegs[e.addr] = e.data;
      end
      if (pushOk) refQ.push_back(pe);
      if (s.stage == STAGE_REGISTER_UPDATE && !(s.instr inside {5'd0, 5'd1, 5'd2, 5'd5}))
        refIllegal = 1'b1;
      refRv = newRv;
      refRd0 = n0;
      refRd1 = n1;
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle status plus operand scoreboard consumed on read_valid.
  always @(negedge clk) begin
    if (statusQ.size() > 0) begin
      status_t st;
      st = statusQ.pop_front();
      checkOutput("queue_count", {29'd0, queue_count}, {29'd0, st.count});
      checkOutput("stall", {31'd0, stall}, {31'd0, st.stall});
      checkOutput("illegal_instr", {31'd0, illegal_instr}, {31'd0, st.illegal});
      checkOutput("read_valid", {31'd0, read_valid}, {31'd0, st.rv});
      checkOutput("read_data_0", read_data_0, st.rd0);
      checkOutput("read_data_1", read_data_1, st.rd1);
    end
    if (read_valid === 1'b1) begin
      if (operandQ.size() == 0) begin
        totalCount++;
        $display("[TB] FAIL operand_underflow: got read_valid=1, expected no pending operands");
      end else begin
        operands_t op;
        op = operandQ.pop_front();
        checkOutput("sb_operand_0", read_data_0, op.rd0);
        checkOutput("sb_operand_1", read_data_1, op.rd1);
      end
    end
  end

  initial begin
    stim_t s;
    logic [4:0] legalTypes [8];
    legalTypes = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd5, 5'd5, 5'd1, 5'd2};

    s = idle();
    s.rst = 1'b1;
    rst = 1'b1; stage = s.stage; instr_type = s.instr;
    load_imm_reg = '0; load_imm_data = '0; load_mem_reg = '0; load_mem_data = '0;
    alu_reg_0 = '0; alu_reg_1 = '0; alu_reg_res = '0; alu_result = '0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    modelReset();

    // Load-immediate then forwarded ALU read
    applyStimulus(loadImm(5'd3, 32'hDEADBEEF, 1'b0));
    checkOutput("li_count_one", {29'd0, queue_count}, 32'd1);
    applyStimulus(aluRead(5'd3, 5'd0));
    checkOutput("fwd_r3", read_data_0, 32'hDEADBEEF);
    applyStimulus(idle());
    applyStimulus(idle());

    // Queue fill under ext_we, stall, then ordered drain
    applyStimulus(loadImm(5'd7, 32'd1, 1'b1));
    applyStimulus(loadImm(5'd7, 32'd2, 1'b1));
    applyStimulus(loadImm(5'd8, 32'd3, 1'b1));
    applyStimulus(loadImm(5'd9, 32'd4, 1'b1));
    applyStimulus(loadImm(5'd10, 32'd5, 1'b1));
    applyStimulus(loadImm(5'd10, 32'd5, 1'b1));
    applyStimulus(loadImm(5'd10, 32'd5, 1'b0));
    applyStimulus(loadImm(5'd10, 32'd5, 1'b0));
    for (int i = 0; i < 6; i++) applyStimulus(idle());
    applyStimulus(aluRead(5'd7, 5'd10));
    checkOutput("r7_final", read_data_0, 32'd2);
    checkOutput("r10_final", read_data_1, 32'd5);

    // Sticky illegal instruction, cleared by reset
    s = idle();
    s.stage = STAGE_REGISTER_UPDATE;
    s.instr = 5'd9;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("illegal_sticky", {31'd0, illegal_instr}, 32'd1);
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("illegal_cleared", {31'd0, illegal_instr}, 32'd0);

    // Reset with queued writes discards them
    applyStimulus(loadImm(5'd4, 32'h44, 1'b1));
    applyStimulus(loadImm(5'd5, 32'h55, 1'b1));
    applyStimulus(loadImm(5'd6, 32'h66, 1'b1));
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("reset_count", {29'd0, queue_count}, 32'd0);
    applyStimulus(aluRead(5'd4, 5'd6));
    checkOutput("reset_r4", read_data_0, 32'd0);

    // Register zero behaviour
    applyStimulus(loadImm(5'd0, 32'd5, 1'b0));
    applyStimulus(idle());
    applyStimulus(aluRead(5'd0, 5'd0));
`ifdef REGFILE_ZERO_REG_EN
    checkOutput("r0_read", read_data_0, 32'd0);
`else
    checkOutput("r0_read", read_data_0, 32'd5);
`endif

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      s = idle();
      s.stage = 3'($urandom_range(0, 4));
      s.instr = ($urandom_range(0, 59) == 0) ? 5'($urandom_range(6, 31)) : legalTypes[$urandom_range(0, 7)];
      s.li_reg = 5'($urandom_range(0, 7));
      s.li_data = $urandom;
      s.lm_reg = 5'($urandom_range(0, 7));
      s.lm_data = $urandom;
      s.a0 = 5'($urandom_range(0, 7));
      s.a1 = 5'($urandom_range(0, 7));
      s.ar = 5'($urandom_range(0, 7));
      s.ares = $urandom;
      s.ext_we = ($urandom_range(0, 3) == 0);
      s.ext_addr = 5'($urandom_range(0, 7));
      s.ext_data = $urandom;
      s.rst = ($urandom_range(0, 149) == 0);
      applyStimulus(s);
    end
    applyStimulus(idle());
    applyStimulus(idle());
    checkOutput("operands_drained", 32'(operandQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Parametrised register-file controller for the multi-cycle TinyCPU core. It owns the register array and selects the writeback source from the current instruction type. Writes are buffered in a small writeback queue, and operand reads forward from that queue. The block sits between the stage sequencer/decoder and the ALU, and back-pressures the sequencer with `stall` when the queue cannot accept a write.

## Interface

Parameters:
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: register address width; the array holds 2^ADDR_WIDTH entries.
- `QUEUE_DEPTH`, 4: writeback queue entries, a power of two ≥ 2.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `stage`  in  3  current CPU stage (package constants).
- `instr_type`  in  5  current instruction type (package constants).
- `load_imm_reg` / `load_imm_data`  in  ADDR_WIDTH / DATA_WIDTH  load-immediate target and value.
- `load_mem_reg` / `load_mem_data`  in  ADDR_WIDTH / DATA_WIDTH  load target and memory data.
- `alu_reg_0`, `alu_reg_1`  in  ADDR_WIDTH  ALU operand sources.
- `alu_reg_res` / `alu_result`  in  ADDR_WIDTH / DATA_WIDTH  ALU destination and result.
- `ext_we`, `ext_addr`, `ext_data`  in  1 / ADDR_WIDTH / DATA_WIDTH  debug write port; writes the array directly.
- `read_data_0`, `read_data_1`  out  DATA_WIDTH  registered operands.
- `read_valid`  out  1  operands valid for the ALU.
- `stall`  out  1  writeback not accepted this cycle; sequencer holds `stage`.
- `queue_count`  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.
- `illegal_instr`  out  1  sticky unknown-instruction flag.

## Operation

**Writeback source selection** (combinational):
- `INSTR_LOAD_IMMEDIATE`: load_imm_reg/data.
- `INSTR_LOAD`: load_mem_reg/data.
- `INSTR_ALU_OP`: alu_reg_res/alu_result.
- `INSTR_NO_OP`: no write.

**Enqueue (push)**:
- `wb_req` = (stage == `STAGE_REGISTER_UPDATE`) && the type writes the register file.
- Push occurs when `wb_req` && !full.
- `stall` = `wb_req` && full. Stall is computed from pre-pop occupancy; there is no same-cycle pass-through.

**Drain (pop)**:
- Each cycle, if the queue is non-empty and `ext_we` == 0, the head entry is written to the array and popped.
- `ext_we` has priority: it writes the array that cycle and the queue does not drain.

**Operand read**:
- Read addresses are `alu_reg_0` / `alu_reg_1` for an ALU op, and 0 otherwise.
- Each read data register loads, every cycle, the youngest queue entry whose address matches (including an entry being pushed this cycle).
- If no entry matches, it loads the array value before this cycle's write (read-old).

**`read_valid`**: registered; high for exactly the one cycle after a cycle with stage == `STAGE_MEMORY_READ` and an ALU op.

**`illegal_instr`**: set when stage == `STAGE_REGISTER_UPDATE` and `instr_type` ∉ {0,1,2,5}; cleared only by `rst`. No write is queued for an illegal instruction.

**Widths**: addresses and data are passed through unmodified. Queue pointers are ADDR-independent and $clog2(QUEUE_DEPTH) bits, wrapping modulo depth. The count is one bit wider than the pointers.

## Timing

**Reset** (synchronous, `rst` high at a rising edge):
- Array is cleared to 0 and the queue is emptied.
- `read_data_*` = 0, `read_valid` = 0, `queue_count` = 0, `illegal_instr` = 0, `stall` = 0.
- Reset mid-operation discards queued writes.

**Latency**:
- Push to array: ≥ 1 cycle (exactly 1 with an empty queue and no `ext_we`).
- Operand read: 1 cycle.
- Push-to-forward: 0 cycles (a same-cycle push is visible at the next edge).

**Boundary cases**:
- Full + `wb_req` + `ext_we`: `stall`=1, no push, no pop.
- Full + `wb_req` + no `ext_we`: `stall`=1, pop proceeds; the push is accepted the next cycle.
- Empty: no array write from the queue.
- Count wraps never; it stays within 0..QUEUE_DEPTH.
- `ext_we` to an address also in the queue: the queued entry later overwrites it.

## Configuration

- `REGFILE_ZERO_REG_EN` defined: register 0 always reads 0. Pushes targeting register 0 are dropped (no queue entry, no stall), and `ext_we` to address 0 is ignored.
- `REGFILE_ZERO_REG_EN` undefined: register 0 is an ordinary register.

## Structure

- Package `tinycpu_pkg` holds:
  - `STAGE_*` constants;
  - `INSTR_*` constants (NO_OP=0, LOAD_IMMEDIATE=1, LOAD=2, ALU_OP=5);
  - a `wb_entry_t` {addr, data} typedef.
- Sub-module `regfile_wb_queue`: circular FIFO with push/pop/count plus two youngest-match lookup ports returning hit and data.

## Test plan

- Load-imm r3=0xDEADBEEF, queue empty → `queue_count` 1 for one cycle, then array r3 = 0xDEADBEEF.
- ALU op reading r3 issued the cycle after that push → `read_data_0` = 0xDEADBEEF via forward, `read_valid` pulses once.
- Hold `ext_we`=1 for 6 cycles while issuing 5 writes → `stall` rises on the 5th `wb_req`. Release → drains in FIFO order; two queued writes to r7 (1, then 2) leave r7 = 2.
- `instr_type`=9 at register-update → `illegal_instr`=1 and stays set; no push. `rst` → 0.
- `rst` asserted with 3 queued entries → `queue_count` 0, operands read 0 next cycle.
- With `REGFILE_ZERO_REG_EN`, load-imm r0=5 → no push, reads of r0 = 0. Without the macro, r0 = 5.
